// File: rtl/can_pkg.sv
// Shared CAN framemaker definitions.
// Provides the error/overload frame state encoding, the frame kind and the
// default flag/delimiter lengths used by error_overload_frame.
package can_pkg;

    typedef enum logic [1:0] {
        EOF_IDLE,
        EOF_FLAG,
        EOF_SUPERPOS,
        EOF_DELIM
    } eofState_t;

    typedef enum logic {
        KIND_ERROR,
        KIND_OVERLOAD
    } frameKind_t;

    localparam int unsigned CAN_FLAG_LEN  = 6;
    localparam int unsigned CAN_DELIM_LEN = 8;

endpackage

// File: rtl/error_overload_frame_bit_counter.sv
// bit_counter: saturating up-counter with clear, load and count enable.
// Ports:
//   clock, resetN  - clock, asynchronous active-low reset
//   clear          - synchronous clear to zero (highest priority)
//   load/loadValue - synchronous load
//   enable         - count up by one, holding at MAX_VALUE
//   count          - current value, $clog2(MAX_VALUE+1) bits
module bit_counter #(
    parameter int unsigned MAX_VALUE = 7,
    parameter int unsigned WIDTH     = $clog2(MAX_VALUE + 1)
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] loadValue,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX_VALUE);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (enable && (count != TOP)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/error_overload_frame.sv
// error_overload_frame: CAN error/overload frame engine.
// Sends the own error/overload flag, tolerates superposed flags, counts the
// recessive delimiter and limits consecutive overload frames.
// Ports:
//   clock, resetN            - clock, asynchronous active-low reset
//   samplePoint              - one-cycle strobe per bit time
//   canRX                    - sampled bus level (0 = dominant)
//   isOverload, isError      - frame requests, sampled on samplePoint
//   errorPassive             - send a recessive (passive) error flag
//   frameStart               - SOF seen, clears the overload counter
//   canTXFlag                - transmit drive, 0 while an active flag is sent
//   busy                     - frame in progress
//   endOverload, endError    - one-cycle completion pulses
//   formError, bitError      - one-cycle error pulses
//   overloadLimit            - one-cycle pulse when an overload is refused
module error_overload_frame
    import can_pkg::*;
#(
    parameter int unsigned FLAG_LEN      = CAN_FLAG_LEN,
    parameter int unsigned DELIM_LEN     = CAN_DELIM_LEN,
    parameter int unsigned MAX_SUPERPOS  = 6,
    parameter int unsigned MAX_OVERLOADS = 2
) (
    input  logic clock,
    input  logic resetN,
    input  logic samplePoint,
    input  logic canRX,
    input  logic isOverload,
    input  logic isError,
    input  logic errorPassive,
    input  logic frameStart,
    output logic canTXFlag,
    output logic busy,
    output logic endOverload,
    output logic endError,
    output logic formError,
    output logic bitError,
    output logic overloadLimit
);

    localparam int unsigned CNT_MAX = (FLAG_LEN > DELIM_LEN) ? FLAG_LEN : DELIM_LEN;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned DCNT_W  = $clog2(MAX_SUPERPOS + 2);
    localparam int unsigned OCNT_W  = $clog2(MAX_OVERLOADS + 1);

    // The accepting strobe is flag bit 0, so the FLAG state itself sees
    // FLAG_LEN-1 more strobes and leaves on the one where cnt = FLAG_LEN-2.
    localparam logic [CNT_W-1:0]  FLAG_LAST  = CNT_W'((FLAG_LEN > 1) ? FLAG_LEN - 2 : 0);
    localparam logic [CNT_W-1:0]  DELIM_LAST = CNT_W'(DELIM_LEN - 1);
    localparam logic [DCNT_W-1:0] DCNT_LAST  = DCNT_W'(MAX_SUPERPOS);
    localparam logic [OCNT_W-1:0] OCNT_LIMIT = OCNT_W'(MAX_OVERLOADS);

    eofState_t  state, stateNext;
    frameKind_t kind, kindNext;

    logic [CNT_W-1:0]  cnt;
    logic [DCNT_W-1:0] dcnt;
    logic [OCNT_W-1:0] ocnt;

    logic cntClear, cntLoad, cntInc;
    logic dcntClear, dcntInc;
    logic ocntInc;
    logic endOvlNext, endErrNext, formErrNext, bitErrNext, limitNext;

    bit_counter #(.MAX_VALUE(CNT_MAX)) cntInst (
        .clock(clock), .resetN(resetN), .clear(cntClear), .load(cntLoad),
        .loadValue(CNT_W'(1)), .enable(cntInc), .count(cnt)
    );

    bit_counter #(.MAX_VALUE(MAX_SUPERPOS + 1)) dcntInst (
        .clock(clock), .resetN(resetN), .clear(dcntClear), .load(1'b0),
        .loadValue('0), .enable(dcntInc), .count(dcnt)
    );

    bit_counter #(.MAX_VALUE(MAX_OVERLOADS)) ocntInst (
        .clock(clock), .resetN(resetN), .clear(frameStart), .load(1'b0),
        .loadValue('0), .enable(ocntInc), .count(ocnt)
    );

    always_comb begin
        stateNext   = state;
        kindNext    = kind;
        cntClear    = 1'b0;
        cntLoad     = 1'b0;
        cntInc      = 1'b0;
        dcntClear   = 1'b0;
        dcntInc     = 1'b0;
        ocntInc     = 1'b0;
        endOvlNext  = 1'b0;
        endErrNext  = 1'b0;
        formErrNext = 1'b0;
        bitErrNext  = 1'b0;
        limitNext   = 1'b0;

        if (samplePoint) begin
            if (isError) begin
                // Error request wins in every state, including IDLE.
                stateNext = EOF_FLAG;
                kindNext  = KIND_ERROR;
                cntClear  = 1'b1;
            end else begin
                unique case (state)
                    EOF_IDLE: begin
                        if (isOverload) begin
                            if (ocnt < OCNT_LIMIT) begin
                                stateNext = EOF_FLAG;
                                kindNext  = KIND_OVERLOAD;
                                cntClear  = 1'b1;
                                ocntInc   = 1'b1;
                            end else begin
                                limitNext = 1'b1;
                            end
                        end
                    end
                    EOF_FLAG: begin
                        // canTXFlag=0 means this bit was driven dominant by us.
                        if (!canTXFlag && canRX) begin
                            bitErrNext = 1'b1;
                            kindNext   = KIND_ERROR;
                            cntClear   = 1'b1;
                        end else if (cnt == FLAG_LAST) begin
                            stateNext = EOF_SUPERPOS;
                            dcntClear = 1'b1;
                        end else begin
                            cntInc = 1'b1;
                        end
                    end
                    EOF_SUPERPOS: begin
                        if (canRX) begin
                            stateNext = EOF_DELIM;
                            cntLoad   = 1'b1;
                        end else if (dcnt == DCNT_LAST) begin
                            formErrNext = 1'b1;
                            dcntClear   = 1'b1;
                        end else begin
                            dcntInc = 1'b1;
                        end
                    end
                    EOF_DELIM: begin
                        if (canRX) begin
                            if (cnt == DELIM_LAST) begin
                                stateNext  = EOF_IDLE;
                                endOvlNext = (kind == KIND_OVERLOAD);
                                endErrNext = (kind == KIND_ERROR);
                            end else begin
                                cntInc = 1'b1;
                            end
                        end else begin
                            stateNext = EOF_FLAG;
                            cntClear  = 1'b1;
                            if (cnt == DELIM_LAST && ocnt < OCNT_LIMIT) begin
                                kindNext = KIND_OVERLOAD;
                                ocntInc  = 1'b1;
                            end else begin
                                kindNext    = KIND_ERROR;
                                limitNext   = (cnt == DELIM_LAST);
                                formErrNext = (cnt != DELIM_LAST);
                            end
                        end
                    end
                    default: stateNext = EOF_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state         <= EOF_IDLE;
            kind          <= KIND_ERROR;
            canTXFlag     <= 1'b1;
            busy          <= 1'b0;
            endOverload   <= 1'b0;
            endError      <= 1'b0;
            formError     <= 1'b0;
            bitError      <= 1'b0;
            overloadLimit <= 1'b0;
        end else begin
            state         <= stateNext;
            kind          <= kindNext;
            endOverload   <= endOvlNext;
            endError      <= endErrNext;
            formError     <= formErrNext;
            bitError      <= bitErrNext;
            overloadLimit <= limitNext;
            if (samplePoint) begin
                canTXFlag <= !((stateNext == EOF_FLAG) &&
                               ((kindNext == KIND_OVERLOAD) || !errorPassive));
                busy      <= (stateNext != EOF_IDLE);
            end
        end
    end

endmodule

// File: doc/error_overload_frame.md
# error_overload_frame

Parametrised error/overload frame engine for the CAN framemaker, replacing the single-purpose overload block. It generates the dominant error or overload flag on the transmit line, tolerates superposed flags from other nodes, and counts the recessive delimiter. It reports end-of-frame, form and bit errors, and limits consecutive overload frames. It sits between the bit-timing unit (which provides the `samplePoint` strobe) and the frame decoder/encoder, which issues `isError` and `isOverload`.

## Interface
Parameters:
- `FLAG_LEN`, 6: length of the own error/overload flag, in bits.
- `DELIM_LEN`, 8: delimiter length, in recessive bits.
- `MAX_SUPERPOS`, 6: dominant bits tolerated after the own flag before `formError` fires.
- `MAX_OVERLOADS`, 2: maximum consecutive overload frames between two `frameStart` pulses.

Ports:
- `clock`, in, 1: system clock.
- `resetN`, in, 1: reset, asynchronous, active-low.
- `samplePoint`, in, 1: one-cycle strobe per bit time. All bit-level actions happen only on cycles where it is 1.
- `canRX`, in, 1: sampled bus level; 0 = dominant.
- `isOverload`, in, 1: overload-frame request, sampled with `samplePoint`.
- `isError`, in, 1: error-frame request, sampled with `samplePoint`.
- `errorPassive`, in, 1: 1 = send a passive (recessive) error flag.
- `frameStart`, in, 1: SOF seen; clears the overload counter.
- `canTXFlag`, out, 1: transmit drive; 0 only while an active flag is sent.
- `busy`, out, 1: frame in progress.
- `endOverload`, out, 1: one-cycle pulse when an overload frame completes.
- `endError`, out, 1: one-cycle pulse when an error frame completes.
- `formError`, out, 1: one-cycle pulse on a superposition overrun or a dominant bit in the delimiter.
- `bitError`, out, 1: one-cycle pulse when recessive is read during own active flag.
- `overloadLimit`, out, 1: one-cycle pulse when an overload is refused.

## Operation
- State machine: IDLE, FLAG, SUPERPOS, DELIM. Registers:
  - bit counter `cnt`;
  - superposition counter `dcnt`;
  - overload counter `ocnt`;
  - frame kind `kind`, error or overload.
- **IDLE.** On a strobe:
  - `isError` → FLAG, kind=error, cnt=0. Error wins if both requests are set; `ocnt` is unchanged.
  - else `isOverload` and `ocnt`<MAX_OVERLOADS → FLAG, kind=overload, cnt=0, `ocnt`++.
  - else `isOverload` with `ocnt`=MAX_OVERLOADS → `overloadLimit` pulse, stay IDLE.
- **FLAG.** The flag lasts FLAG_LEN strobes; cnt counts 0..FLAG_LEN-1, then → SUPERPOS with dcnt=0.
  - Active flag (kind=overload, or error with `errorPassive`=0): `canTXFlag`=0.
  - Passive flag: `canTXFlag`=1, and no bit check.
  - Active flag with `canRX`=1 at a strobe → `bitError` pulse; restart FLAG as an error frame, cnt=0.
- **SUPERPOS.** `canTXFlag`=1.
  - `canRX`=0 → dcnt++. When dcnt reaches MAX_SUPERPOS+1 → `formError` pulse, dcnt=0, stay in SUPERPOS.
  - `canRX`=1 → DELIM, cnt=1. This bit is the first delimiter bit.
- **DELIM.**
  - `canRX`=1 → cnt++. When cnt reaches DELIM_LEN → `endOverload` or `endError` pulse (per kind), IDLE.
  - `canRX`=0 while cnt=DELIM_LEN-1 (last delimiter bit): start a new overload frame (FLAG, kind=overload) if `ocnt`<MAX_OVERLOADS, with `ocnt`++. Otherwise `overloadLimit` pulse and start an error frame.
  - `canRX`=0 earlier in DELIM → `formError` pulse, error frame.
- **Mid-frame requests.**
  - `isError` asserted mid-frame (any non-IDLE state, at a strobe) → restart FLAG as an error frame, cnt=0.
  - `isOverload` is ignored while `busy`=1.
- `frameStart` (any cycle) → `ocnt`=0. It does not affect the state.
- Counter widths are `$clog2(max+1)`. Counters saturate, never wrap.

## Timing
- Reset values: state=IDLE, `canTXFlag`=1, `busy`=0, all pulses 0, `ocnt`=0. Reset is asynchronous, so it takes effect mid-frame at once.
- All outputs are registered. A request accepted at strobe n gives `canTXFlag`=0 and `busy`=1 from the cycle after n, until the cycle after strobe n+FLAG_LEN-1.
- Pulses are high for exactly one clock, the cycle after the triggering strobe.
- `busy` falls in the same cycle that `endOverload` or `endError` rises.
- With no superposition, the frame is FLAG_LEN+DELIM_LEN strobes.
- Inputs have no effect between strobes, except `frameStart` and `resetN`.

## Structure
- Shared package `can_pkg`:
  - state enum (`EOF_IDLE`, `EOF_FLAG`, `EOF_SUPERPOS`, `EOF_DELIM`);
  - kind enum;
  - default constants `CAN_FLAG_LEN`=6 and `CAN_DELIM_LEN`=8.
- One sub-module, `bit_counter`: saturating up-counter with enable/clear/load, parameterised by max value. It is instantiated for `cnt`, `dcnt` and `ocnt`.

## Test plan
All scenarios use default parameters; "strobe" is one `samplePoint` pulse.
1. `isOverload`=1 at strobe 0, `canRX`=0 for strobes 0–5, then `canRX`=1 for 16 strobes → `canTXFlag`=0 for exactly 6 bits. `endOverload` pulses after the 8th recessive strobe (strobe 13). `busy`=0 afterwards. No `formError`.
2. As 1, but `canRX`=0 for 10 strobes (4 superposed) → no `formError`. `endOverload` after 8 recessive bits (strobe 17).
3. As 1, but 7 superposed dominant bits → `formError` pulse on the 7th.
4. `isError`=`isOverload`=1 at the same strobe, `errorPassive`=0 → error frame, `endError` pulse, `ocnt` stays 0. Same stimulus with `errorPassive`=1 → `canTXFlag` never 0.
5. Dominant on delimiter bit 8, twice in a row → two chained overload frames. On the third, `overloadLimit` pulses and an error frame starts. Then `frameStart`, then `isOverload` → accepted.
6. `canRX`=1 at flag bit 3 of an active flag → `bitError` pulse and the flag restarts. Then `resetN`=0 mid-flag → `canTXFlag`=1 and `busy`=0 immediately, without waiting for a clock edge.
